// File: rtl/i2s_tx_unit.sv
// ---------------------------------------------------------------------------
// i2s_tx_unit
//
// Serialises stereo 24-bit samples as an I2S stream. Runs entirely in the
// mclk domain and consumes the sample stream that the cdc_unit delivers.
// A one-sample holding buffer takes each tick_in. A play/flush state machine
// turns that buffer into frames of 48 bits. The first bit of each frame is
// the left MSB. Once per frame, req_out asks the CDC for the next sample.
//
// Ports
//   clk           in   clock (mclk after cdc_unit muxing)
//   rst           in   synchronous reset, active-high
//   play_in       in   playback enable, level
//   tick_in       in   one-cycle strobe, audio0_in/audio1_in valid
//   audio0_in     in   [23:0] left sample, two's complement
//   audio1_in     in   [23:0] right sample, two's complement
//   req_out       out  one-cycle request for the next sample
//   sck_out       out  I2S bit clock
//   ws_out        out  I2S word select (0 = left, 1 = right)
//   sdo_out       out  I2S serial data, MSB first
//   underrun_out  out  sticky: a frame started without a fresh sample
//
// Handshake: tick_in is a strobe with no back-pressure. The sample in the
// tick_in cycle is always accepted. It overwrites any unconsumed one.
// ---------------------------------------------------------------------------
module i2s_tx_unit #(
    parameter int MCLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_in,
    input  logic        tick_in,
    input  logic [23:0] audio0_in,
    input  logic [23:0] audio1_in,
    output logic        req_out,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sdo_out,
    output logic        underrun_out
);

    localparam int DC_W = $clog2(MCLK_DIV) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [DC_W-1:0]   r_dc;
    logic [5:0]        r_b;
    logic [47:0]       r_hold;
    logic              r_hold_valid;
    logic [47:0]       r_shift;
    logic              r_req;
    logic              r_sck;
    logic              r_ws;
    logic              r_sdo;
    logic              r_underrun;

    logic              w_dc_end;
    logic              w_wrap;
    logic              w_continue;
    logic              w_frame_f;
    logic [47:0]       w_next_frame;

    // ws leads the data by one bit, so it rises on the last left bit.
    function automatic logic ws_for(input logic [5:0] b);
        return (b >= 6'd23) && (b <= 6'd46);
    endfunction

    assign w_dc_end     = (r_dc == DC_W'(MCLK_DIV - 1));
    // The last bit of the frame ends on the sck fall that follows b = 47.
    assign w_wrap       = (r_state != ST_IDLE) && w_dc_end && r_sck && (r_b == 6'd47);
    // A flushing frame resumes seamlessly when play comes back, even at the wrap.
    assign w_continue   = (r_state == ST_PLAY) || play_in;
    assign w_frame_f    = ((r_state == ST_IDLE) && play_in) || (w_wrap && w_continue);
    assign w_next_frame = r_hold_valid ? r_hold : 48'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dc         <= '0;
            r_b          <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_req        <= 1'b0;
            r_sck        <= 1'b0;
            r_ws         <= 1'b0;
            r_sdo        <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dc  <= '0;
                    r_b   <= '0;
                    r_sck <= 1'b0;
                    r_ws  <= 1'b0;
                    r_sdo <= 1'b0;
                    if (play_in) begin
                        // The entry frame plays whatever sits in holding.
                        // This is not counted as an underrun.
                        r_state    <= ST_PLAY;
                        r_shift    <= r_hold;
                        r_sdo      <= r_hold[47];
                        r_req      <= 1'b1;
                        r_underrun <= 1'b0;
                    end
                end
                default: begin
                    if (!w_dc_end) begin
                        r_dc <= r_dc + DC_W'(1);
                    end else begin
                        r_dc  <= '0;
                        r_sck <= ~r_sck;
                        if (r_sck) begin
                            if (r_b != 6'd47) begin
                                r_b     <= r_b + 6'd1;
                                r_shift <= r_shift << 1;
                                r_sdo   <= r_shift[46];
                                r_ws    <= ws_for(r_b + 6'd1);
                            end else if (w_continue) begin
                                r_b     <= '0;
                                r_shift <= w_next_frame;
                                r_sdo   <= w_next_frame[47];
                                r_ws    <= 1'b0;
                                r_req   <= 1'b1;
                                if (!r_hold_valid) begin
                                    r_underrun <= 1'b1;
                                end
                            end else begin
                                r_b   <= '0;
                                r_ws  <= 1'b0;
                                r_sdo <= 1'b0;
                            end
                        end
                    end
                    if (w_wrap && !w_continue) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= play_in ? ST_PLAY : ST_FLUSH;
                    end
                end
            endcase

            // A tick in the same cycle as a frame start lands after the
            // consume. The new sample is then kept for the next frame.
            if (w_frame_f) begin
                r_hold_valid <= 1'b0;
            end
            if (tick_in) begin
                r_hold       <= {audio0_in, audio1_in};
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign req_out      = r_req;
    assign sck_out      = r_sck;
    assign ws_out       = r_ws;
    assign sdo_out      = r_sdo;
    assign underrun_out = r_underrun;

endmodule

// File: tb/tb_i2s_tx_unit.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_unit
//
// Two instances run side by side on the same inputs. One uses MCLK_DIV=2 and
// the other uses MCLK_DIV=1. Each instance has a frame-level reference model.
// The model counts cycles since the frame start and derives sck, bit index,
// ws and data from that count. The model pushes the expected ws/sdo for each
// sck rise and the cycle of each req_out into queues. A monitor on the
// falling edge pops and compares whenever the DUT shows an sck rise or a
// req_out.
// ---------------------------------------------------------------------------
module tb_i2s_tx_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play_in = 1'b0;
    logic        tick_in = 1'b0;
    logic [23:0] audio0_in = '0;
    logic [23:0] audio1_in = '0;

    int  n_checks = 0;
    int  n_errs   = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;
    bit  done     = 1'b0;

    // ------------------------------------------------------------ clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst,
                         input logic [47:0] got, input logic [47:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errs++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h",
                     name, inst, cyc, got, exp_v);
        end
    endtask

    // ------------------------------------------------- DUTs, models, monitors
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int D = (gi == 0) ? 2 : 1;

        logic req_out, sck_out, ws_out, sdo_out, underrun_out;

        i2s_tx_unit #(.MCLK_DIV(D)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .play_in      (play_in),
            .tick_in      (tick_in),
            .audio0_in    (audio0_in),
            .audio1_in    (audio1_in),
            .req_out      (req_out),
            .sck_out      (sck_out),
            .ws_out       (ws_out),
            .sdo_out      (sdo_out),
            .underrun_out (underrun_out)
        );

        int          m_t = 0;
        bit          m_active = 1'b0;
        bit          m_prev_play = 1'b0;
        logic [47:0] m_hold = '0;
        bit          m_valid = 1'b0;
        logic [47:0] m_frame = '0;
        bit          m_under = 1'b0;
        bit          m_sck = 1'b0;
        logic [7:0]  exp_q[$];   // {bit index, ws, sdo}
        int          req_q[$];   // cycle numbers of expected req_out
        logic        prev_sck = 1'b0;
        bit          fin = 1'b0;

        // Reference model. A frame lasts 96*D cycles, counted from its start.
        always @(posedge clk) begin : p_model
            bit f;
            int bi;
            f = 1'b0;
            if (rst) begin
                m_active = 1'b0;
                m_t      = 0;
                m_under  = 1'b0;
                m_hold   = '0;
                m_valid  = 1'b0;
            end else begin
                if (!m_active) begin
                    if (play_in) begin
                        m_active = 1'b1;
                        m_t      = 0;
                        m_frame  = m_hold;
                        m_under  = 1'b0;
                        f        = 1'b1;
                    end
                end else begin
                    m_t++;
                    if (m_t == 96 * D) begin
                        m_t = 0;
                        if (play_in || m_prev_play) begin
                            f = 1'b1;
                            if (m_valid) begin
                                m_frame = m_hold;
                            end else begin
                                m_frame = '0;
                                m_under = 1'b1;
                            end
                        end else begin
                            m_active = 1'b0;
                        end
                    end
                end
                if (f) begin
                    m_valid = 1'b0;
                    req_q.push_back(cyc + 1);  // cyc advances on this same edge
                end
                if (tick_in) begin
                    m_hold  = {audio0_in, audio1_in};
                    m_valid = 1'b1;
                end
            end
            m_prev_play = play_in;
            m_sck = m_active && ((m_t % (2 * D)) >= D);
            if (m_active && ((m_t % (2 * D)) == D)) begin
                bi = m_t / (2 * D);
                exp_q.push_back({6'(bi), (bi >= 23 && bi <= 46), m_frame[47 - bi]});
            end
        end

        always @(negedge clk) begin : p_monitor
            logic [7:0] item;
            if (mon_en) begin
                check("sck", gi, 48'(sck_out), 48'(m_sck));
                check("underrun", gi, 48'(underrun_out), 48'(m_under));
                if (!m_active) begin
                    check("idle_ws_sdo", gi, 48'({ws_out, sdo_out}), 48'(0));
                end
                if (req_q.size() > 0 && req_q[0] < cyc) begin
                    check("req_missing", gi, 48'(0), 48'(req_q[0]));
                    void'(req_q.pop_front());
                end
                if (req_out) begin
                    if (req_q.size() == 0) begin
                        check("req_unexpected", gi, 48'(cyc), 48'(0));
                    end else begin
                        check("req_cycle", gi, 48'(cyc), 48'(req_q.pop_front()));
                    end
                end
                if (sck_out && !prev_sck) begin
                    if (exp_q.size() == 0) begin
                        check("sck_rise_unexpected", gi, 48'(cyc), 48'(0));
                    end else begin
                        item = exp_q.pop_front();
                        check($sformatf("ws_sdo_bit%0d", item[7:2]), gi,
                              48'({ws_out, sdo_out}), 48'(item[1:0]));
                    end
                end
                prev_sck = sck_out;
                if (done && !fin) begin
                    fin = 1'b1;
                    check("bits_left", gi, 48'(exp_q.size()), 48'(0));
                    check("reqs_left", gi, 48'(req_q.size()), 48'(0));
                end
            end
        end
    end

    // ----------------------------------------------------------- driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input logic [23:0] l, input logic [23:0] r);
        tick_in   = 1'b1;
        audio0_in = l;
        audio1_in = r;
        step(1);
        tick_in   = 1'b0;
    endtask

    // Wait until the MCLK_DIV=2 model reaches cycle t of an active frame.
    task automatic wait_t(input int target);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            step(1);
            if (g_inst[0].m_active && g_inst[0].m_t == target) reached = 1'b1;
        end
        check("wait_frame_pos", 0, 48'(reached), 48'(1));
    endtask

    // --------------------------------------------------------------- stimulus
    logic [23:0] stream_l [4] = '{24'h000001, 24'h800000, 24'h7FFFFF, 24'hFFFFFF};

    initial begin
        step(1);
        mon_en = 1'b1;
        step(1);
        rst = 1'b0;
        step(200);                                 // idle, everything at 0

        tick(24'hA5A5A5, 24'h3C3C3C);
        play_in = 1'b1;                            // entry frame
        for (int k = 0; k < 4; k++) begin          // streaming
            wait_t(20);
            tick(stream_l[k], 24'($urandom));
        end
        wait_t(20);                                // last streamed frame
        wait_t(20);                                // underrun frame
        wait_t(20);                                // second underrun frame
        tick(24'($urandom), 24'($urandom));

        wait_t(40);                                // b = 10: start flush
        play_in = 1'b0;
        step(300);
        play_in = 1'b1;                            // entry clears underrun
        wait_t(20);
        tick(24'($urandom), 24'($urandom));
        wait_t(40);
        play_in = 1'b0;
        wait_t(120);                               // b = 30 of flushing frame
        play_in = 1'b1;

        wait_t(191);                               // tick at the wrap
        tick(24'($urandom), 24'($urandom));
        wait_t(20);
        wait_t(20);

        wait_t(80);                                // b = 20: reset mid-frame
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        wait_t(20);

        for (int k = 0; k < 10; k++) begin
            step($urandom_range(30, 300));
            case ($urandom_range(0, 2))
                0: play_in = ~play_in;
                default: tick(24'($urandom), 24'($urandom));
            endcase
        end

        play_in = 1'b0;
        step(450);
        done = 1'b1;
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_tx_unit.md
Name: i2s_tx_unit

Overview:
- mclk-domain consumer of the sample stream that the cdc_unit delivers from the clk domain.
- Accepts stereo 24-bit samples on tick_in and serialises them as an I2S stream (sck_out, ws_out, sdo_out).
- Issues req_out once per frame to pull the next sample back across the CDC.
- Has a one-sample holding buffer and a play/flush state machine.

Parameters:
MCLK_DIV, 2, clk cycles per SCK half-period; legal range 1..16; one bit lasts 2*MCLK_DIV cycles; one frame lasts 96*MCLK_DIV cycles.

Ports:
clk  input  1  clock; the only clock (mclk after cdc_unit muxing)
rst  input  1  synchronous reset, active-high
play_in  input  1  playback enable, level
tick_in  input  1  one-cycle strobe; audio0_in/audio1_in are valid in that cycle
audio0_in  input  24  left sample, two's complement
audio1_in  input  24  right sample, two's complement
req_out  output  1  one-cycle request for the next sample
sck_out  output  1  I2S bit clock
ws_out  output  1  I2S word select; 0 = left, 1 = right
sdo_out  output  1  I2S serial data, MSB first
underrun_out  output  1  sticky flag: a frame started with no new sample available

Behaviour:
- Reset (rst=1 at a clk edge): all outputs take their reset values on that edge.
  - req_out=0, sck_out=0, ws_out=0, sdo_out=0, underrun_out=0.
  - State=IDLE; holding register, shift register, hold_valid, bit counter b and divider dc all cleared.
  - Reset mid-frame aborts the frame immediately; no req_out is issued.
- All outputs are registered.
- States: IDLE, PLAY, FLUSH.
  - IDLE: outputs idle at 0; dc and b held at 0; tick_in is still captured into the holding register.
- Frame-start event F: loads shift <= {holding L, holding R} and pulses req_out=1 for exactly that cycle.
  - F occurs on entry IDLE->PLAY (play_in=1 sampled in IDLE).
  - F also occurs on the b wrap 47->0 while in PLAY.
- At F, if hold_valid=0: shift is loaded with zeros, and underrun_out is set.
  - Exception: the entry F, which uses the holding contents without flagging.
- At F, hold_valid is cleared.
- tick_in in any state: holding <= {audio0_in, audio1_in} and hold_valid <= 1. A newer tick overwrites an unconsumed sample (newest wins).
- tick_in in the same cycle as F: shift takes the OLD holding value; the new sample lands in holding with hold_valid=1.
- Bit timing in PLAY/FLUSH:
  - dc counts 0..MCLK_DIV-1.
  - When dc=MCLK_DIV-1, dc returns to 0 and sck_out toggles.
  - On the cycle sck_out goes 1->0, b advances (47 wraps to 0) and ws_out/sdo_out update in that same cycle.
  - The entry cycle presents b=0 with sck_out=0.
- Bit mapping (b = 0..47):
  - sdo_out = L[23-b] for b<24, R[47-b] otherwise.
  - ws_out = 1 for b in 23..46, else 0. ws leads data by one bit (standard I2S delay).
- PLAY with play_in=0 -> FLUSH. The current frame completes.
- FLUSH, b wraps 47->0 -> IDLE.
  - No F and no req_out at that boundary.
  - sck_out, ws_out, sdo_out return to 0 in the same cycle.
- FLUSH with play_in=1 -> PLAY, seamless: no bit slip, and the next wrap is a normal F.
- underrun_out clears only on rst or on the entry F.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, play_in=0 for 200 cycles -> all outputs 0 throughout; no req_out.
- Single frame, MCLK_DIV=2:
  - Stimulus: tick with L=0xA5A5A5, R=0x3C3C3C; then play_in=1.
  - Required: req_out at entry and again 192 cycles later; bit period of 4 cycles.
  - sdo sampled on sck rising edges = 0xA5A5A5 then 0x3C3C3C, MSB first.
  - ws high for b=23..46; no underrun.
- Streaming: tick with a new sample 20 cycles after each req_out for 4 frames, values 0x000001, 0x800000, 0x7FFFFF, 0xFFFFFF -> each frame carries the previous tick's sample; underrun_out stays 0.
- Underrun: stop ticking after frame 2 -> frame 3 is all-zero data; underrun_out=1 from its F and stays 1 until the next entry F.
- Flush/resume:
  - Stimulus: drop play_in at b=10.
  - Required: the frame completes; outputs go to 0 at the wrap; no req_out there.
  - Second stimulus: re-assert play_in at b=30 of a flushing frame -> no gap; req_out at the next wrap.
- Edge cases:
  - tick_in coincident with F -> the current frame uses the old sample; the next frame uses the new one.
  - rst=1 at b=20 -> all outputs 0 on the next edge.
  - MCLK_DIV=1 -> bit period of 2 cycles, frame of 96 cycles.
